uart_rx_ctrl: RTL and testbench

// - Frame controller for the UART receive path. Sequences one frame: start, 8 data bits, optional parity, stop.
// - Owns the oversampling edge counter and the frame bit counter.
// - Drives the data sampler enable and the deserializer write strobe (deser_en, bit_cnt).
// - Checks start glitch, parity and stop bit; flags a good frame with data_valid.
// - Sits between the RX pin synchroniser/data sampler and the deserializer, inside UART_RX.

---
 rtl/uart_rx_pkg.sv | 28 ++
 rtl/uart_rx_edge_bit_cnt.sv | 59 +++++
 rtl/uart_rx_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
// Holds the FSM state encoding, default widths and the bit_cnt positions used by the
// frame controller and its counter sub-module.
package uart_rx_pkg;

  localparam int unsigned DEF_PRESC_W   = 6;
  localparam int unsigned DEF_DATA_BITS = 8;

  // Frame bit positions
  localparam logic [3:0] BIT_START = 4'd0;
  localparam logic [3:0] BIT_PAR   = 4'd9;

  // State encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = ST_IDLE,
    StStart  = ST_START,
    StData   = ST_DATA,
    StParity = ST_PARITY,
    StStop   = ST_STOP
  } state_e;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and frame bit counter.
// Ports:
//   CLK, RST_n  clock, asynchronous active-low reset
//   en          advance edge_cnt this cycle
//   clr         zero both counters (takes priority over en)
//   load        capture presc_in as the ratio for the coming frame
//   presc_in    oversampling ratio
//   edge_cnt    tick within the current bit, 0..ratio-1
//   bit_cnt     frame bit index
//   bit_end     edge_cnt is on the last tick of the bit
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESC_W = DEF_PRESC_W
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               en,
  input  logic               clr,
  input  logic               load,
  input  logic [PRESC_W-1:0] presc_in,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               bit_end
);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] edge_q;
  logic [3:0]         bit_q;

  assign bit_end  = (edge_q == presc_q - PRESC_W'(1));
  assign edge_cnt = edge_q;
  assign bit_cnt  = bit_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      presc_q <= '0;
      edge_q  <= '0;
      bit_q   <= BIT_START;
    end else begin
      if (load) begin
        presc_q <= presc_in;
      end
      if (clr) begin
        edge_q <= '0;
        bit_q  <= BIT_START;
      end else if (en) begin
        // On the load cycle presc_q still holds the previous ratio, so never wrap there.
        if (bit_end && !load) begin
          edge_q <= '0;
          bit_q  <= bit_q + 4'd1;
        end else begin
          edge_q <= edge_q + PRESC_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start, DATA_BITS data bits, optional parity, stop.
// Ports:
//   CLK, RST_n   oversampling clock, asynchronous active-low reset
//   RX_IN        synchronised serial line, idle high
//   PAR_EN       parity bit present; PAR_TYP 0 even / 1 odd
//   Prescale     oversampling ratio (8, 16, 32)
//   sampled_bit  majority-voted bit, valid on the last tick of each bit
//   dat_samp_en  data sampler enable
//   edge_cnt     tick within current bit; bit_cnt frame bit index
//   deser_en     deserializer write strobe, one per data bit
//   data_valid   one-cycle pulse for an error-free frame
//   par_err      parity error of the last frame, held until next start
//   stp_err      stop error of the last frame, held until next start
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESC_W   = DEF_PRESC_W,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               sampled_bit,
  output logic               dat_samp_en,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               deser_en,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err
);

  state_e state_q, state_d;
  logic   par_en_q, par_typ_q;
  logic   parity_q, parity_d;
  logic   par_err_q, par_err_d;
  logic   stp_err_q, stp_err_d;
  logic   start_det, bit_end, cnt_clr;

  assign start_det = (state_q == StIdle) && !RX_IN;

  uart_rx_edge_bit_cnt #(
    .PRESC_W (PRESC_W)
  ) u_cnt (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .en       ((state_q != StIdle) || start_det),
    .clr      (cnt_clr),
    .load     (start_det),
    .presc_in (Prescale),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_end  (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    parity_d   = parity_q;
    par_err_d  = par_err_q;
    stp_err_d  = stp_err_q;
    deser_en   = 1'b0;
    data_valid = 1'b0;
    cnt_clr    = 1'b0;
    case (state_q)
      StIdle: begin
        if (!RX_IN) begin
          state_d   = StStart;
          parity_d  = 1'b0;
          par_err_d = 1'b0;
          stp_err_d = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          if (sampled_bit) begin
            // Line went back high: glitch, not a start bit
            state_d = StIdle;
            cnt_clr = 1'b1;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (bit_end) begin
          deser_en = 1'b1;
          parity_d = parity_q ^ sampled_bit;
          if (bit_cnt == 4'(DATA_BITS)) begin
            state_d = par_en_q ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          par_err_d = sampled_bit != (parity_q ^ par_typ_q);
          state_d   = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          stp_err_d  = ~sampled_bit;
          // par_err is final here; it only changes in PARITY or at start
          data_valid = sampled_bit && !par_err_q;
          state_d    = StIdle;
          cnt_clr    = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= StIdle;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      parity_q  <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      parity_q  <= parity_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
      if (start_det) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
    end
  end

  assign dat_samp_en = (state_q != StIdle);
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl. The bench plays the role of the data sampler, driving
// sampled_bit with the value of each frame bit for the whole bit period.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic       RX_IN, PAR_EN, PAR_TYP, sampled_bit;
  logic [5:0] Prescale;
  logic       dat_samp_en, deser_en, data_valid, par_err, stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;

  int total = 0;
  int bad   = 0;

  // Observations gathered by drive_frame
  int         deser_cnt, dv_cnt, dv_cyc, dv_abs, overlap, gcyc;
  int         deser_cyc[8];
  logic [3:0] deser_bit[8];
  logic       samp_gap, par_err_at1, stp_err_at1;

  uart_rx_ctrl dut (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .Prescale    (Prescale),
    .sampled_bit (sampled_bit),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .deser_en    (deser_en),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Drives one whole frame, starting in the current (idle) cycle. Config inputs are
  // scrambled after the detect cycle to show they are latched.
  task automatic drive_frame(input logic [7:0] data, input logic pe, input logic pt,
                             input logic pb, input logic sb, input logic [5:0] presc);
    int nbits;
    int ncyc;
    nbits = pe ? 11 : 10;
    ncyc  = nbits * int'(presc);
    deser_cnt = 0; dv_cnt = 0; dv_cyc = -1; dv_abs = -1; overlap = 0; samp_gap = 1'b0;
    for (int k = 0; k < 8; k++) begin
      deser_cyc[k] = -1;
      deser_bit[k] = 4'hf;
    end
    for (int c = 0; c < ncyc; c++) begin
      int   b;
      logic v;
      b = c / int'(presc);
      if (b == 0) v = 1'b0;
      else if (b <= 8) v = data[b-1];
      else if (b == 9 && pe) v = pb;
      else v = sb;
      RX_IN = v;
      sampled_bit = v;
      if (c == 0) begin
        PAR_EN = pe; PAR_TYP = pt; Prescale = presc;
      end else begin
        PAR_EN = ~pe; PAR_TYP = ~pt; Prescale = 6'd13;
      end
      @(negedge CLK);
      if (deser_en) begin
        if (deser_cnt < 8) begin
          deser_cyc[deser_cnt] = c;
          deser_bit[deser_cnt] = bit_cnt;
        end
        deser_cnt++;
      end
      if (data_valid) begin
        dv_cnt++; dv_cyc = c; dv_abs = gcyc;
      end
      if (deser_en && data_valid) overlap++;
      if (c > 0 && !dat_samp_en) samp_gap = 1'b1;
      if (c == 1) begin
        par_err_at1 = par_err; stp_err_at1 = stp_err;
      end
      @(posedge CLK); #1;
      gcyc++;
    end
    RX_IN = 1'b1; sampled_bit = 1'b1; PAR_EN = pe; PAR_TYP = pt; Prescale = presc;
  endtask

  task automatic test_reset();
    #3;
    total++; if ({dat_samp_en, deser_en, data_valid, par_err, stp_err} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000",
                      {dat_samp_en, deser_en, data_valid, par_err, stp_err});
    end
    total++; if ({edge_cnt, bit_cnt} !== 10'd0) begin
      bad++; $display("FAIL reset_cnt: got edge=%0d bit=%0d want 0/0", edge_cnt, bit_cnt);
    end
    @(negedge CLK); RST_n = 1'b1;
    repeat (2) @(posedge CLK); #1;
    total++; if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0) begin
      bad++; $display("FAIL idle_after_reset: samp_en=%b edge=%0d want 0/0",
                      dat_samp_en, edge_cnt);
    end
  endtask

  // 1,0,1,0,0,1,0,1 on the line = 8'hA5 (LSB first), even parity 0
  task automatic test_good_parity();
    drive_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 6'd8);
    total++; if (deser_cnt !== 8) begin
      bad++; $display("FAIL good_deser_cnt: got %0d want 8", deser_cnt);
    end
    for (int k = 0; k < 8; k++) begin
      total++; if (deser_cyc[k] !== (k + 2) * 8 - 1 || deser_bit[k] !== 4'(k + 1)) begin
        bad++; $display("FAIL good_deser_%0d: got cyc=%0d bit=%0d want cyc=%0d bit=%0d",
                        k, deser_cyc[k], deser_bit[k], (k + 2) * 8 - 1, k + 1);
      end
    end
    // Detect cycle is index 0, so the stop bit end is the 88th cycle of the frame
    total++; if (dv_cnt !== 1 || dv_cyc !== 87) begin
      bad++; $display("FAIL good_dv: got cnt=%0d cyc=%0d want 1/87", dv_cnt, dv_cyc);
    end
    total++; if (par_err !== 1'b0 || stp_err !== 1'b0) begin
      bad++; $display("FAIL good_flags: got par=%b stp=%b want 0/0", par_err, stp_err);
    end
    total++; if (overlap !== 0 || samp_gap !== 1'b0) begin
      bad++; $display("FAIL good_misc: overlap=%0d samp_gap=%b want 0/0", overlap, samp_gap);
    end
    @(negedge CLK);
    total++; if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0 || bit_cnt !== 4'd0) begin
      bad++; $display("FAIL good_back_idle: samp_en=%b edge=%0d bit=%0d want 0/0/0",
                      dat_samp_en, edge_cnt, bit_cnt);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_parity_err();
    drive_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 6'd8);
    total++; if (par_err !== 1'b1 || stp_err !== 1'b0) begin
      bad++; $display("FAIL perr_flags: got par=%b stp=%b want 1/0", par_err, stp_err);
    end
    total++; if (dv_cnt !== 0 || deser_cnt !== 8) begin
      bad++; $display("FAIL perr_pulses: got dv=%0d deser=%0d want 0/8", dv_cnt, deser_cnt);
    end
    drive_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 6'd8);
    total++; if (par_err_at1 !== 1'b0) begin
      bad++; $display("FAIL perr_clear_at_start: got %b want 0", par_err_at1);
    end
    total++; if (dv_cnt !== 1 || par_err !== 1'b0) begin
      bad++; $display("FAIL perr_recover: got dv=%0d par=%b want 1/0", dv_cnt, par_err);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    Prescale = 6'd8; sampled_bit = 1'b1;
    for (int c = 0; c < 12; c++) begin
      RX_IN = (c < 3) ? 1'b0 : 1'b1;
      @(negedge CLK);
      if (deser_en || data_valid) pulses++;
      if (c == 1) begin
        total++; if (edge_cnt !== 6'd1 || dat_samp_en !== 1'b1) begin
          bad++; $display("FAIL glitch_edge1: got edge=%0d samp_en=%b want 1/1",
                          edge_cnt, dat_samp_en);
        end
      end
      if (c == 8) begin
        total++; if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0 || bit_cnt !== 4'd0) begin
          bad++; $display("FAIL glitch_idle: samp_en=%b edge=%0d bit=%0d want 0/0/0",
                          dat_samp_en, edge_cnt, bit_cnt);
        end
      end
      @(posedge CLK); #1;
    end
    total++; if (pulses !== 0 || par_err !== 1'b0 || stp_err !== 1'b0) begin
      bad++; $display("FAIL glitch_quiet: pulses=%0d par=%b stp=%b want 0/0/0",
                      pulses, par_err, stp_err);
    end
  endtask

  task automatic test_stop_err();
    drive_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 6'd16);
    total++; if (stp_err !== 1'b1 || par_err !== 1'b0) begin
      bad++; $display("FAIL serr_flags: got stp=%b par=%b want 1/0", stp_err, par_err);
    end
    total++; if (dv_cnt !== 0 || deser_cnt !== 8) begin
      bad++; $display("FAIL serr_pulses: got dv=%0d deser=%0d want 0/8", dv_cnt, deser_cnt);
    end
    total++; if (deser_cyc[7] !== 9 * 16 - 1 || deser_bit[7] !== 4'd8) begin
      bad++; $display("FAIL serr_last_deser: got cyc=%0d bit=%0d want 143/8",
                      deser_cyc[7], deser_bit[7]);
    end
    @(negedge CLK);
    total++; if (dat_samp_en !== 1'b0 || stp_err !== 1'b1) begin
      bad++; $display("FAIL serr_idle: samp_en=%b stp=%b want 0/1", dat_samp_en, stp_err);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_frame();
    Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0; sampled_bit = 1'b0; RX_IN = 1'b0;
    @(posedge CLK); #1;
    RX_IN = 1'b1;
    repeat (35) @(posedge CLK);
    #1;
    total++; if (bit_cnt !== 4'd4 || dat_samp_en !== 1'b1) begin
      bad++; $display("FAIL rst_mid_pre: got bit=%0d samp_en=%b want 4/1", bit_cnt, dat_samp_en);
    end
    #2 RST_n = 1'b0;
    #1;
    total++; if ({dat_samp_en, deser_en, data_valid, par_err, stp_err, edge_cnt, bit_cnt}
                 !== 15'd0) begin
      bad++; $display("FAIL rst_mid_async: samp_en=%b deser=%b dv=%b par=%b stp=%b edge=%0d bit=%0d want all 0",
                      dat_samp_en, deser_en, data_valid, par_err, stp_err, edge_cnt, bit_cnt);
    end
    sampled_bit = 1'b1;
    @(negedge CLK); RST_n = 1'b1;
    @(posedge CLK); #1;
    drive_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8);
    total++; if (dv_cnt !== 1 || deser_cnt !== 8 || dv_cyc !== 79) begin
      bad++; $display("FAIL rst_mid_recover: got dv=%0d deser=%0d dv_cyc=%0d want 1/8/79",
                      dv_cnt, deser_cnt, dv_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int first_dv;
    drive_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 6'd16);
    first_dv = dv_abs;
    total++; if (dv_cnt !== 1) begin
      bad++; $display("FAIL b2b_first: got dv=%0d want 1", dv_cnt);
    end
    drive_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 6'd16);
    total++; if (dv_cnt !== 1 || dv_abs - first_dv !== 160) begin
      bad++; $display("FAIL b2b_second: got dv=%0d spacing=%0d want 1/160",
                      dv_cnt, dv_abs - first_dv);
    end
    total++; if (deser_cnt !== 8 || overlap !== 0) begin
      bad++; $display("FAIL b2b_deser: got deser=%0d overlap=%0d want 8/0", deser_cnt, overlap);
    end
  endtask

  initial begin
    RST_n = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
    sampled_bit = 1'b1; gcyc = 0;
    test_reset();
    test_good_parity();
    test_parity_err();
    test_glitch();
    test_stop_err();
    test_reset_mid_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
